// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver for the shift-register serial link.
// Frame on sdi = start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// The line is sampled only on clocks where bit_en=1. Good words are held in a one-word
// output buffer with a valid/ready handshake. Framing errors and overruns are flagged
// as single-cycle pulses.
// Optional feature: define SIPO_FRAME_RX_PARITY_EN to add the parity bit and the parity_err port.
module sipo_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
`ifdef SIPO_FRAME_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              stop_sample;
    logic              par_bad;
    logic              word_good;
`ifdef SIPO_FRAME_RX_PARITY_EN
    logic              par_q, par_d;
    logic              parity_err_q, parity_err_d;
`endif

    // State register: every flop of the receiver, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit counting and shifting, all frozen while bit_en=0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (bit_en && !sdi) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], sdi};
                    end else begin
                        shreg_d = {sdi, shreg_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SIPO_FRAME_RX_PARITY_EN
            PARITY: begin
                if (bit_en) begin
                    par_d   = sdi;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: stop-bit verdict, one-word buffer with handshake, and the error pulses
    always_comb begin
        stop_sample = (state_q == STOP) && bit_en;
`ifdef SIPO_FRAME_RX_PARITY_EN
        par_bad     = ^{shreg_q, par_q};
`else
        par_bad     = 1'b0;
`endif
        word_good    = stop_sample && sdi && !par_bad;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready;
        frame_err_d  = stop_sample && !sdi;
        overrun_d    = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
        parity_err_d = stop_sample && sdi && par_bad;
`endif
        if (word_good) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = shreg_q;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end
        busy = (state_q != IDLE);
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: drives one serial line into two receivers (MSB-first and LSB-first)
// and compares both against a frame-level reference model.
// Define SIPO_FRAME_RX_PARITY_EN to exercise the parity variant.
module tb_sipo_frame_rx;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, bit_en, sdi, dout_ready;
    logic [W-1:0] dout_m, dout_l;
    logic         valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l, busy_m, busy_l;
`ifdef SIPO_FRAME_RX_PARITY_EN
    logic         perr_m, perr_l;
`endif

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .frame_err(ferr_m), .overrun(ovr_m),
`ifdef SIPO_FRAME_RX_PARITY_EN
        .parity_err(perr_m),
`endif
        .busy(busy_m)
    );

    sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .sdi(sdi),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .frame_err(ferr_l), .overrun(ovr_l),
`ifdef SIPO_FRAME_RX_PARITY_EN
        .parity_err(perr_l),
`endif
        .busy(busy_l)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state: the buffered word as seen by each receiver, plus shared flags
    logic [W-1:0] exp_dout_m = '0;
    logic [W-1:0] exp_dout_l = '0;
    logic         exp_valid  = 1'b0;
    logic         exp_busy   = 1'b0;
    logic [W-1:0] cur_m, cur_l;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic e_ferr, input logic e_ovr, input logic e_perr);
        checkOutput({tag, "/dout_m"}, 32'(dout_m), 32'(exp_dout_m));
        checkOutput({tag, "/dout_l"}, 32'(dout_l), 32'(exp_dout_l));
        checkOutput({tag, "/valid_m"}, 32'(valid_m), 32'(exp_valid));
        checkOutput({tag, "/valid_l"}, 32'(valid_l), 32'(exp_valid));
        checkOutput({tag, "/ferr_m"}, 32'(ferr_m), 32'(e_ferr));
        checkOutput({tag, "/ferr_l"}, 32'(ferr_l), 32'(e_ferr));
        checkOutput({tag, "/ovr_m"}, 32'(ovr_m), 32'(e_ovr));
        checkOutput({tag, "/ovr_l"}, 32'(ovr_l), 32'(e_ovr));
        checkOutput({tag, "/busy_m"}, 32'(busy_m), 32'(exp_busy));
        checkOutput({tag, "/busy_l"}, 32'(busy_l), 32'(exp_busy));
`ifdef SIPO_FRAME_RX_PARITY_EN
        checkOutput({tag, "/perr_m"}, 32'(perr_m), 32'(e_perr));
        checkOutput({tag, "/perr_l"}, 32'(perr_l), 32'(e_perr));
`else
        if (e_perr) $display("[TB] unexpected parity event in %s", tag);
`endif
    endtask

    // One clock: drive inputs, step the model on the edge, compare #1 later.
    // ev: 0 nothing, 1 good stop bit, 2 stop bit low, 3 parity wrong
    task automatic applyStimulus(input logic en, input logic s, input logic rdy, input int ev,
                                 input logic busy_after, input string tag);
        logic e_ferr, e_ovr, e_perr;
        e_ferr = 1'b0;
        e_ovr  = 1'b0;
        e_perr = 1'b0;
        bit_en     = en;
        sdi        = s;
        dout_ready = rdy;
        @(posedge clk);
        #1;
        if (exp_valid && rdy) exp_valid = 1'b0;
        if (ev == 1) begin
            if (!exp_valid) begin
                exp_dout_m = cur_m;
                exp_dout_l = cur_l;
                exp_valid  = 1'b1;
            end else begin
                e_ovr = 1'b1;
            end
        end else if (ev == 2) begin
            e_ferr = 1'b1;
        end else if (ev == 3) begin
            e_perr = 1'b1;
        end
        exp_busy = busy_after;
        checkAll(tag, e_ferr, e_ovr, e_perr);
    endtask

    task automatic checkReset(input string tag);
        exp_dout_m = '0;
        exp_dout_l = '0;
        exp_valid  = 1'b0;
        exp_busy   = 1'b0;
        checkAll(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n, input int ready_mode, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1,
                          (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode),
                          0, 1'b0, tag);
        end
    endtask

    // Sends one frame whose data bits go out word[7] first. ready_mode: 0 low, 1 high, 2 random.
    // abort_after > 0 pulses rst_n right after that many data bits were sampled.
    task automatic sendFrame(input logic [W-1:0] word, input logic stop_bit, input logic par_bit,
                             input int period, input int abort_after, input int ready_mode,
                             input string tag);
        logic bits[$];
        logic par_wrong;
        int   ev;
        logic en, rdy, busy_after;
        bits.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(word[W-1-i]);
`ifdef SIPO_FRAME_RX_PARITY_EN
        bits.push_back(par_bit);
        par_wrong = (^word) ^ par_bit;
`else
        par_wrong = 1'b0;
        if (par_bit === 1'bx) $display("[TB] parity bit ignored");
`endif
        bits.push_back(stop_bit);
        cur_m = word;
        cur_l = '0;
        for (int i = 0; i < W; i++) cur_l = cur_l | (W'(bits[1+i]) << i);
        for (int k = 0; k < bits.size(); k++) begin
            for (int p = 0; p < period; p++) begin
                en         = (p == period - 1);
                ev         = 0;
                busy_after = exp_busy;
                if (en && k == 0) busy_after = 1'b1;
                if (en && k == bits.size() - 1) begin
                    busy_after = 1'b0;
                    ev = !stop_bit ? 2 : (par_wrong ? 3 : 1);
                end
                rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
                applyStimulus(en, bits[k], rdy, ev, busy_after, tag);
                if (en && abort_after > 0 && k == abort_after) begin
                    #2;
                    rst_n  = 1'b0;
                    bit_en = 1'b0;
                    sdi    = 1'b1;
                    #1;
                    checkReset({tag, "/in_reset"});
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    checkReset({tag, "/after_reset"});
                    return;
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        bit_en     = 1'b0;
        sdi        = 1'b1;
        dout_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #10;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] idle line");
        idleCycles(20, 0, "idle");

        $display("[TB] single frame 0x3F then accept");
        sendFrame(8'h3F, 1'b1, 1'b0, 1, 0, 0, "f3f");
        checkOutput("msb_3f", 32'(dout_m), 32'h3F);
        idleCycles(1, 1, "accept3f");
        idleCycles(2, 0, "gap1");

        $display("[TB] bit order frame");
        sendFrame(8'hA0, 1'b1, 1'b0, 1, 0, 0, "fa0");
        checkOutput("lsb_05", 32'(dout_l), 32'h05);
        idleCycles(1, 1, "accepta0");

        $display("[TB] back-to-back with consumer stalled");
        sendFrame(8'hA5, 1'b1, 1'b0, 1, 0, 0, "b2b_a5");
        sendFrame(8'h3C, 1'b1, 1'b0, 1, 0, 0, "b2b_3c");
        checkOutput("held_a5", 32'(dout_m), 32'hA5);
        idleCycles(1, 1, "accept_a5");

        $display("[TB] back-to-back with consumer ready");
        sendFrame(8'hA5, 1'b1, 1'b1, 1, 0, 1, "rdy_a5");
        sendFrame(8'h3C, 1'b1, 1'b0, 1, 0, 1, "rdy_3c");
        checkOutput("new_3c", 32'(dout_m), 32'h3C);
        idleCycles(2, 1, "drain");

        $display("[TB] framing error then good frame");
        sendFrame(8'h3F, 1'b0, 1'b0, 1, 0, 0, "ferr");
        sendFrame(8'h81, 1'b1, 1'b0, 1, 0, 0, "f81");
        checkOutput("got_81", 32'(dout_m), 32'h81);
        idleCycles(1, 1, "accept81");

        $display("[TB] slow strobe with reset mid-frame");
        sendFrame(8'h5A, 1'b1, 1'b0, 4, 4, 0, "abort");
        sendFrame(8'h5A, 1'b1, 1'b0, 4, 0, 0, "f5a");
        checkOutput("got_5a", 32'(dout_m), 32'h5A);
        idleCycles(1, 1, "accept5a");

`ifdef SIPO_FRAME_RX_PARITY_EN
        $display("[TB] parity frames");
        sendFrame(8'h3F, 1'b1, 1'b1, 1, 0, 0, "par_bad");
        sendFrame(8'h3C, 1'b1, 1'b0, 1, 0, 0, "par_ok");
        checkOutput("par_3c", 32'(dout_m), 32'h3C);
        idleCycles(1, 1, "acceptpar");
`endif

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            sendFrame(w, ($urandom_range(0, 7) != 0),
                      (^w) ^ ($urandom_range(0, 5) == 0),
                      $urandom_range(1, 3), 0, 2, "rand");
            idleCycles($urandom_range(0, 2), 2, "rgap");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
